hs_fifo_responder: RTL and testbench

- Buffered responder end of the req/ack pull handshake used between dataflow operators.
- Accepts words from a synchronous valid/ready stream (memory reader, DMA, bench stimulus) into a circular FIFO.
- Serves those words to one downstream requester (an operator input port or `out` node) with one-cycle ack pulses.
- Replaces free-running sources wherever real, finite, possibly bursty data must feed the graph.

---
 rtl/hs_fifo_responder_if.sv | 25 ++
 rtl/hs_fifo_responder.sv | 70 +++++++
 tb/tb_hs_fifo_responder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_fifo_responder_if.sv
// Signal bundle for hs_fifo_responder: valid/ready stream in, req/ack pull port out,
// plus occupancy and served-word counters.
interface hs_fifo_responder_if #(
    parameter int data_width = 32,
    parameter int depth      = 8
);
    logic                   s_valid;
    logic                   s_ready;
    logic [data_width-1:0]  s_data;
    logic                   req;
    logic                   ack;
    logic [data_width-1:0]  dout;
    logic [$clog2(depth):0] level;
    logic [31:0]            count;

    modport master (
        output s_valid, s_data, req,
        input  s_ready, ack, dout, level, count
    );

    modport slave (
        input  s_valid, s_data, req,
        output s_ready, ack, dout, level, count
    );
endinterface

// File: rtl/hs_fifo_responder.sv
// Buffered responder for the req/ack pull handshake: a circular FIFO filled from a
// valid/ready stream and drained one word per ack pulse to a single requester.
module hs_fifo_responder #(
    parameter int                    data_width    = 32,
    parameter int                    depth         = 8,
    parameter logic [data_width-1:0] initial_value = '0
) (
    input  logic                clk,
    input  logic                rst,
    hs_fifo_responder_if.slave  bus
);
    localparam int aw = $clog2(depth);
    localparam int pw = aw + 1;

    logic [data_width-1:0] mem_r [depth];
    logic [pw-1:0]         wr_ptr_r;
    logic [pw-1:0]         rd_ptr_r;
    logic                  ack_r;
    logic [data_width-1:0] dout_r;
    logic [31:0]           count_r;

    logic [pw-1:0]         level_s;
    logic                  empty_s;
    logic                  full_s;
    logic                  push_s;
    logic                  pop_s;

    // Occupancy from the pointer difference (extra MSB separates full from empty) and transfer qualifiers
    always_comb begin
        level_s = wr_ptr_r - rd_ptr_r;
        empty_s = (level_s == pw'(0));
        full_s  = (level_s == pw'(depth));
        push_s  = bus.s_valid & ~full_s;
        pop_s   = bus.req & ~ack_r & ~empty_s;
    end

    // Storage array; contents are don't-care after reset, so it carries no reset term
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[aw-1:0]] <= bus.s_data;
        end
    end

    // Pointers, ack pulse, served word and served count; ~ack_r in pop_s spaces serves two cycles apart
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= pw'(0);
            rd_ptr_r <= pw'(0);
            ack_r    <= 1'b0;
            dout_r   <= initial_value;
            count_r  <= 32'd0;
        end else begin
            ack_r <= pop_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + pw'(1);
            end
            if (pop_s) begin
                dout_r   <= mem_r[rd_ptr_r[aw-1:0]];
                rd_ptr_r <= rd_ptr_r + pw'(1);
                count_r  <= count_r + 32'd1;
            end
        end
    end

    assign bus.s_ready = ~full_s;
    assign bus.ack     = ack_r;
    assign bus.dout    = dout_r;
    assign bus.level   = level_s;
    assign bus.count   = count_r;
endmodule

// File: tb/tb_hs_fifo_responder.sv
// Randomised self-checking bench for hs_fifo_responder against a queue-based reference model.
module tb_hs_fifo_responder;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;

    hs_fifo_responder_if #(.data_width(DW), .depth(DEPTH)) bus ();

    hs_fifo_responder #(
        .data_width   (DW),
        .depth        (DEPTH),
        .initial_value(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [31:0] m_q[$];
    bit          m_ack;
    logic [31:0] m_dout;
    logic [31:0] m_count;
    int          checks = 0;
    int          errors = 0;

    // Advance the model by the rules for one rising edge, then the clock; outputs are read 1ns after the edge.
    task automatic tick();
        bit pu;
        bit po;
        if (rst) begin
            m_q.delete();
            m_ack   = 1'b0;
            m_dout  = 32'h0;
            m_count = 32'd0;
        end else begin
            pu = bus.s_valid && (m_q.size() < DEPTH);
            po = bus.req && !m_ack && (m_q.size() > 0);
            m_ack = po;
            if (po) begin
                m_dout  = m_q.pop_front();
                m_count = m_count + 32'd1;
            end
            if (pu) m_q.push_back(bus.s_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req = 1'b1; bus.s_valid = 1'b0; bus.s_data = 32'h0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.ack !== 1'b0 || bus.dout !== 32'h0 || bus.level !== 4'd0 ||
                bus.count !== 32'd0 || bus.s_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset[%0d]: ack=%b dout=%h level=%0d count=%0d s_ready=%b, required 0/0/0/0/1",
                         i, bus.ack, bus.dout, bus.level, bus.count, bus.s_ready);
            end
        end
        rst = 1'b0; bus.req = 1'b0;
    endtask

    task automatic test_basic_order();
        logic [31:0] got[$];
        bit prev_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.s_valid = (i < 3);
            bus.s_data  = 32'd10 + 32'(i);
            bus.req     = !bus.ack;
            tick();
            checks++;
            if (bus.ack !== m_ack || (m_ack && bus.dout !== m_dout)) begin
                errors++;
                $display("FAIL basic_cycle[%0d]: ack=%b dout=%0d, required ack=%b dout=%0d", i, bus.ack, bus.dout, m_ack, m_dout);
            end
            if (bus.ack === 1'b1 && prev_ack) begin
                errors++;
                $display("FAIL basic_double_ack[%0d]: ack high two cycles, required single pulse", i);
            end
            if (bus.ack === 1'b1) got.push_back(bus.dout);
            prev_ack = (bus.ack === 1'b1);
        end
        checks++;
        if (got.size() != 3 || got[0] !== 32'd10 || got[1] !== 32'd11 || got[2] !== 32'd12) begin
            errors++;
            $display("FAIL basic_sequence: got %0d words %p, required 10 11 12", got.size(), got);
        end
        checks++;
        if (bus.count !== 32'd3 || bus.level !== 4'd0 || bus.ack !== 1'b0) begin
            errors++;
            $display("FAIL basic_final: count=%0d level=%0d ack=%b, required 3/0/0", bus.count, bus.level, bus.ack);
        end
        bus.req = 1'b0; bus.s_valid = 1'b0;
    endtask

    task automatic test_full();
        logic [31:0] got[$];
        bus.req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.s_valid = 1'b1; bus.s_data = 32'(i);
            tick();
        end
        checks++;
        if (bus.s_ready !== 1'b0 || bus.level !== 4'd8) begin
            errors++;
            $display("FAIL full_flag: s_ready=%b level=%0d, required 0/8", bus.s_ready, bus.level);
        end
        bus.s_data = 32'd99;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.level !== 4'd8 || bus.ack !== 1'b0) begin
                errors++;
                $display("FAIL full_blocked[%0d]: level=%0d ack=%b, required 8/0", i, bus.level, bus.ack);
            end
        end
        bus.req = 1'b1;
        tick();
        checks++;
        if (bus.ack !== 1'b1 || bus.dout !== 32'd0 || bus.level !== 4'd7 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_serve: ack=%b dout=%0d level=%0d s_ready=%b, required 1/0/7/1", bus.ack, bus.dout, bus.level, bus.s_ready);
        end
        got.push_back(bus.dout);
        bus.req = 1'b0;
        tick();
        checks++;
        if (bus.level !== 4'd8) begin
            errors++;
            $display("FAIL full_accept99: level=%0d, required 8", bus.level);
        end
        bus.s_valid = 1'b0;
        for (int i = 0; i < 60 && got.size() < 9; i++) begin
            bus.req = !bus.ack;
            tick();
            checks++;
            if (bus.ack !== m_ack || (m_ack && bus.dout !== m_dout)) begin
                errors++;
                $display("FAIL full_drain[%0d]: ack=%b dout=%0d, required ack=%b dout=%0d", i, bus.ack, bus.dout, m_ack, m_dout);
            end
            if (bus.ack === 1'b1) got.push_back(bus.dout);
        end
        checks++;
        if (got.size() != 9 || got[8] !== 32'd99) begin
            errors++;
            $display("FAIL full_order_len: got %0d words %p, required 0..7 then 99", got.size(), got);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== 32'(i)) begin
                    errors++;
                    $display("FAIL full_order[%0d]: got %0d, required %0d", i, got[i], i);
                end
            end
        end
        bus.req = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [31:0] got[$];
        logic [31:0] want[$] = '{32'd101, 32'd102, 32'd103, 32'd200};
        bus.req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.s_valid = 1'b1; bus.s_data = 32'd100 + 32'(i);
            tick();
        end
        bus.s_data = 32'd200; bus.req = 1'b1;
        tick();
        checks++;
        if (bus.level !== 4'd4 || bus.ack !== 1'b1 || bus.dout !== 32'd100) begin
            errors++;
            $display("FAIL simul_push_pop: level=%0d ack=%b dout=%0d, required 4/1/100", bus.level, bus.ack, bus.dout);
        end
        bus.s_valid = 1'b0;
        for (int i = 0; i < 40 && got.size() < 4; i++) begin
            bus.req = !bus.ack;
            tick();
            if (bus.ack === 1'b1) got.push_back(bus.dout);
        end
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL simul_order: got %p, required %p", got, want);
        end
        bus.req = 1'b0;
        tick();
    endtask

    task automatic test_late_arrival();
        bus.req = 1'b1; bus.s_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (bus.ack !== 1'b0) begin
                errors++;
                $display("FAIL late_empty_ack[%0d]: ack=%b, required 0", i, bus.ack);
            end
        end
        bus.s_valid = 1'b1; bus.s_data = 32'h55;
        tick();
        checks++;
        if (bus.ack !== 1'b0 || bus.level !== 4'd1) begin
            errors++;
            $display("FAIL late_no_bypass: ack=%b level=%0d, required 0/1", bus.ack, bus.level);
        end
        bus.s_valid = 1'b0;
        tick();
        checks++;
        if (bus.ack !== 1'b1 || bus.dout !== 32'h55 || bus.level !== 4'd0) begin
            errors++;
            $display("FAIL late_serve: ack=%b dout=%h level=%0d, required 1/55/0", bus.ack, bus.dout, bus.level);
        end
        tick();
        checks++;
        if (bus.ack !== 1'b0 || bus.dout !== 32'h55) begin
            errors++;
            $display("FAIL late_single_pulse: ack=%b dout=%h, required 0/55", bus.ack, bus.dout);
        end
        bus.req = 1'b0;
        tick();
    endtask

    task automatic test_wrap_and_reset();
        int  next_word = 0;
        int  out_idx   = 0;
        bit  prev_ack  = 1'b0;
        bit  accepted;
        bus.s_valid = 1'b0; bus.req = 1'b0;
        for (int cyc = 0; cyc < 2000 && out_idx < 20; cyc++) begin
            if (!bus.s_valid && next_word < 20) begin
                bus.s_valid = ($urandom_range(0, 3) != 0);
                bus.s_data  = 32'(next_word);
            end
            bus.req  = ($urandom_range(0, 2) != 0) && !bus.ack;
            accepted = bus.s_valid && bus.s_ready;
            tick();
            if (accepted) begin
                next_word++;
                bus.s_valid = 1'b0;
            end
            checks++;
            if (bus.ack !== m_ack || (bus.ack === 1'b1 && bus.dout !== 32'(out_idx))) begin
                errors++;
                $display("FAIL wrap_cycle[%0d]: ack=%b dout=%0d, required ack=%b dout=%0d", cyc, bus.ack, bus.dout, m_ack, out_idx);
            end
            if (bus.ack === 1'b1 && prev_ack) begin
                errors++;
                $display("FAIL wrap_double_ack[%0d]: ack high two cycles, required single pulse", cyc);
            end
            if (bus.ack === 1'b1) out_idx++;
            prev_ack = (bus.ack === 1'b1);
        end
        checks++;
        if (out_idx != 20) begin
            errors++;
            $display("FAIL wrap_timeout: served %0d words, required 20", out_idx);
        end
        bus.s_valid = 1'b0; bus.req = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.s_valid = 1'b1; bus.s_data = 32'd300 + 32'(i);
            tick();
        end
        bus.s_valid = 1'b0; bus.req = 1'b1;
        tick();
        checks++;
        if (bus.ack !== 1'b1 || bus.level !== 4'd3 || bus.dout !== 32'd300) begin
            errors++;
            $display("FAIL midreset_setup: ack=%b level=%0d dout=%0d, required 1/3/300", bus.ack, bus.level, bus.dout);
        end
        rst = 1'b1; bus.req = 1'b0;
        tick();
        checks++;
        if (bus.ack !== 1'b0 || bus.level !== 4'd0 || bus.dout !== 32'h0 ||
            bus.count !== 32'd0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: ack=%b level=%0d dout=%0d count=%0d s_ready=%b, required 0/0/0/0/1",
                     bus.ack, bus.level, bus.dout, bus.count, bus.s_ready);
        end
        rst = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 32'h77;
        tick();
        bus.s_valid = 1'b0; bus.req = 1'b1;
        tick();
        checks++;
        if (bus.ack !== 1'b1 || bus.dout !== 32'h77 || bus.count !== 32'd1 || bus.level !== 4'd0) begin
            errors++;
            $display("FAIL midreset_first: ack=%b dout=%h count=%0d level=%0d, required 1/77/1/0",
                     bus.ack, bus.dout, bus.count, bus.level);
        end
        bus.req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_full();
        test_simultaneous();
        test_late_arrival();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
